// File: rtl/oldland_memory_stage_pkg.sv
// Shared width codes, FSM state type and request validation for the memory stage.
package oldland_memory_stage_pkg;

  localparam logic [1:0] MEM_WIDTH_8  = 2'b00;
  localparam logic [1:0] MEM_WIDTH_16 = 2'b01;
  localparam logic [1:0] MEM_WIDTH_32 = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 256;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  // Reserved width counts as misaligned so both abort through the same path.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    logic bad;
    case (width)
      MEM_WIDTH_8:  bad = 1'b0;
      MEM_WIDTH_16: bad = lo[0];
      MEM_WIDTH_32: bad = (lo != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/oldland_mem_lanes.sv
// Little-endian byte-lane steering: store lane enables/replication and load extraction.
module oldland_mem_lanes
  import oldland_memory_stage_pkg::*;
(
  input  logic [1:0]  req_width,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_data,
  output logic [3:0]  bytesel,
  output logic [31:0] wr_data,
  input  logic [1:0]  ld_width,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_val
);

  always_comb begin
    bytesel = '0;
    wr_data = '0;
    case (req_width)
      MEM_WIDTH_8: begin
        bytesel = 4'b0001 << req_lo;
        wr_data = {4{req_data[7:0]}};
      end
      MEM_WIDTH_16: begin
        bytesel = req_lo[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_data[15:0]}};
      end
      MEM_WIDTH_32: begin
        bytesel = '1;
        wr_data = req_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_val = '0;
    case (ld_width)
      MEM_WIDTH_8:  ld_val = {24'b0, ld_data[{ld_lo, 3'b000} +: 8]};
      MEM_WIDTH_16: ld_val = {16'b0, ld_data[{ld_lo[1], 4'b0000} +: 16]};
      MEM_WIDTH_32: ld_val = ld_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/oldland_memory_stage.sv
// Memory pipeline stage: one outstanding data-bus access with ack/error/timeout,
// then a registered writeback result; stalls upstream while the access is open.
module oldland_memory_stage
  import oldland_memory_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [1:0]  mem_width,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [31:0] wr_val,
  input  logic        wr_result,
  input  logic [3:0]  rd_sel,
  input  logic        i_valid,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  output logic        d_access,
  input  logic        d_ack,
  input  logic        d_error,
  input  logic [31:0] d_data,
  output logic        busy,
  output logic [31:0] wb_val,
  output logic        wb_en,
  output logic [3:0]  wb_rd_sel,
  output logic        i_valid_out,
  output logic        data_abort
);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             ld_q, wr_result_q;
  logic [1:0]       width_q, lo_q;
  logic [3:0]       rd_q;
  logic [3:0]       req_bytesel;
  logic [31:0]      req_wr_data, ld_val;
  logic             valid_req, bad_req, start, ack_done, abort_done, done;

  oldland_mem_lanes u_lanes (
    .req_width (mem_width),
    .req_lo    (mar[1:0]),
    .req_data  (mdr),
    .bytesel   (req_bytesel),
    .wr_data   (req_wr_data),
    .ld_width  (width_q),
    .ld_lo     (lo_q),
    .ld_data   (d_data),
    .ld_val    (ld_val)
  );

  assign valid_req = i_valid & (mem_load | mem_store);
  assign bad_req   = misaligned(mem_width, mar[1:0]);
  assign start     = (state == S_IDLE) && valid_req && !bad_req;
  // Error beats a simultaneous ack; an ack on the timeout cycle still completes.
  assign abort_done = (state == S_ACCESS) &&
                      (d_error || (!d_ack && count == CNT_W'(TIMEOUT_CYCLES - 1)));
  assign ack_done   = (state == S_ACCESS) && d_ack && !d_error;
  assign done       = abort_done | ack_done;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_ACCESS;
        busy       = 1'b1;
      end
      S_ACCESS: if (done) state_next = S_IDLE;
                else      busy       = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      d_addr      <= '0;
      d_bytesel   <= '0;
      d_wr_val    <= '0;
      d_wr_en     <= 1'b0;
      d_access    <= 1'b0;
      ld_q        <= 1'b0;
      wr_result_q <= 1'b0;
      width_q     <= '0;
      lo_q        <= '0;
      rd_q        <= '0;
      wb_val      <= '0;
      wb_en       <= 1'b0;
      wb_rd_sel   <= '0;
      i_valid_out <= 1'b0;
      data_abort  <= 1'b0;
    end else begin
      wb_val      <= '0;
      wb_en       <= 1'b0;
      wb_rd_sel   <= '0;
      i_valid_out <= 1'b0;
      data_abort  <= 1'b0;
      case (state)
        S_IDLE: begin
          count <= '0;
          if (!valid_req) begin
            wb_val      <= wr_val;
            wb_en       <= wr_result & i_valid;
            wb_rd_sel   <= rd_sel;
            i_valid_out <= i_valid;
          end else if (bad_req) begin
            data_abort <= 1'b1;
          end else begin
            d_access    <= 1'b1;
            d_addr      <= {mar[31:2], 2'b00};
            d_bytesel   <= req_bytesel;
            d_wr_val    <= req_wr_data;
            d_wr_en     <= mem_store;
            ld_q        <= mem_load;
            width_q     <= mem_width;
            lo_q        <= mar[1:0];
            rd_q        <= rd_sel;
            wr_result_q <= wr_result;
          end
        end
        S_ACCESS: begin
          count <= count + CNT_W'(1);
          if (done) begin
            d_access <= 1'b0;
            d_wr_en  <= 1'b0;
          end
          if (abort_done) begin
            data_abort <= 1'b1;
          end else if (ack_done) begin
            i_valid_out <= 1'b1;
            wb_en       <= ld_q & wr_result_q;
            wb_val      <= ld_q ? ld_val : '0;
            wb_rd_sel   <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_memory_stage.sv
// Scoreboard bench: driver pushes expected writeback/bus events, monitors pop and compare.
module tb_oldland_memory_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mar, mdr, wr_val, d_data;
  logic [1:0]  mem_width;
  logic        mem_load, mem_store, wr_result, i_valid, d_ack, d_error;
  logic [3:0]  rd_sel;
  logic [31:0] d_addr, d_wr_val, wb_val;
  logic [3:0]  d_bytesel, wb_rd_sel;
  logic        d_wr_en, d_access, busy, wb_en, i_valid_out, data_abort;

  always #5 clk = ~clk;

  oldland_memory_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mar(mar), .mdr(mdr), .mem_width(mem_width),
    .mem_load(mem_load), .mem_store(mem_store), .wr_val(wr_val),
    .wr_result(wr_result), .rd_sel(rd_sel), .i_valid(i_valid),
    .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_val(d_wr_val),
    .d_wr_en(d_wr_en), .d_access(d_access), .d_ack(d_ack), .d_error(d_error),
    .d_data(d_data), .busy(busy), .wb_val(wb_val), .wb_en(wb_en),
    .wb_rd_sel(wb_rd_sel), .i_valid_out(i_valid_out), .data_abort(data_abort)
  );

  typedef struct {
    logic        iv, en, abort, chk_val, chk_rd;
    logic [31:0] val;
    logic [3:0]  rd;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr, wr_val;
    logic [3:0]  bytesel;
    logic        wr_en;
  } bus_exp_t;

  typedef enum int {R_ACK, R_ERR, R_BOTH, R_TMO} resp_t;

  wb_exp_t     exp_q[$];
  bus_exp_t    bus_q[$];
  int unsigned vectors = 0, miscompares = 0;
  logic        bus_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] lanes_of(input logic [31:0] a, input logic [1:0] w);
    int unsigned m;
    m = ((32'd1 << nbytes(w)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] rep_of(input logic [31:0] d, input logic [1:0] w);
    case (nbytes(w))
      1:       return {24'b0, d[7:0]} * 32'h01010101;
      2:       return {16'b0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [31:0] a,
                                          input logic [1:0] w);
    logic [63:0] mask;
    mask = (64'd1 << (8 * nbytes(w))) - 64'd1;
    return 32'(({32'b0, d} >> (8 * (a % 4))) & mask);
  endfunction

  initial begin : wb_mon
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (i_valid_out || wb_en || data_abort)) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb", {29'b0, i_valid_out, wb_en, data_abort}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("i_valid_out", {31'b0, i_valid_out}, {31'b0, e.iv});
          chk("wb_en", {31'b0, wb_en}, {31'b0, e.en});
          chk("data_abort", {31'b0, data_abort}, {31'b0, e.abort});
          if (e.chk_val) chk("wb_val", wb_val, e.val);
          if (e.chk_rd) chk("wb_rd_sel", {28'b0, wb_rd_sel}, {28'b0, e.rd});
        end
      end
    end
  end

  initial begin : bus_mon
    forever begin
      @(negedge clk);
      if (d_access) begin
        if (bus_q.size() == 0) begin
          chk("spurious_access", {31'b0, d_access}, 32'h0);
        end else begin
          chk("d_addr", d_addr, bus_q[0].addr);
          chk("d_bytesel", {28'b0, d_bytesel}, {28'b0, bus_q[0].bytesel});
          chk("d_wr_val", d_wr_val, bus_q[0].wr_val);
          chk("d_wr_en", {31'b0, d_wr_en}, {31'b0, bus_q[0].wr_en});
        end
      end else if (bus_prev && bus_q.size() != 0) begin
        void'(bus_q.pop_front());
      end
      bus_prev = d_access;
    end
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      mar = $urandom; mdr = $urandom; mem_width = 2'($urandom);
      mem_load = 1'($urandom); mem_store = 1'($urandom);
      wr_val = $urandom; wr_result = 1'($urandom); rd_sel = 4'($urandom);
      i_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_alu(input logic [31:0] wv, input logic wr, input logic [3:0] rd);
    mar = $urandom; mdr = $urandom; mem_width = 2'($urandom);
    mem_load = 1'b0; mem_store = 1'b0;
    wr_val = wv; wr_result = wr; rd_sel = rd; i_valid = 1'b1;
    exp_q.push_back('{iv: 1'b1, en: wr, abort: 1'b0, chk_val: 1'b1, chk_rd: 1'b1, val: wv, rd: rd});
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic issue_mem(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                           input logic st, input logic wr, input logic [3:0] rd,
                           input resp_t resp, input int unsigned rc, input logic [31:0] rdata);
    bit          bad, fin;
    int unsigned nb, exp_nb;
    bad = (w == 2'd3) || ((a % nbytes(w)) != 0);
    mar = a; mdr = d; mem_width = w; mem_load = !st; mem_store = st;
    wr_val = $urandom; wr_result = wr; rd_sel = rd; i_valid = 1'b1;
    if (bad) begin
      exp_q.push_back('{iv: 1'b0, en: 1'b0, abort: 1'b1, chk_val: 1'b0, chk_rd: 1'b0, val: '0, rd: '0});
      @(negedge clk);
      chk("busy_bad_req", {31'b0, busy}, 32'h0);
      @(posedge clk); #1;
      i_valid = 1'b0;
      return;
    end
    bus_q.push_back('{addr: {a[31:2], 2'b00}, wr_val: rep_of(d, w), bytesel: lanes_of(a, w), wr_en: st});
    if (resp == R_ACK)
      exp_q.push_back('{iv: 1'b1, en: !st && wr, abort: 1'b0, chk_val: !st, chk_rd: !st,
                        val: extract(rdata, a, w), rd: rd});
    else
      exp_q.push_back('{iv: 1'b0, en: 1'b0, abort: 1'b1, chk_val: 1'b0, chk_rd: 1'b0, val: '0, rd: '0});
    exp_nb = (resp == R_TMO) ? TO : rc;
    nb = 0;
    fin = 1'b0;
    @(negedge clk);
    if (busy) nb++;
    @(posedge clk); #1;
    for (int unsigned k = 1; k <= 20; k++) begin
      d_ack   = (resp == R_ACK || resp == R_BOTH) && k == rc;
      d_error = (resp == R_ERR || resp == R_BOTH) && k == rc;
      d_data  = (k == rc) ? rdata : $urandom;
      @(negedge clk);
      if (busy) nb++;
      else fin = 1'b1;
      @(posedge clk); #1;
      d_ack = 1'b0; d_error = 1'b0;
      if (fin) break;
    end
    chk("access_completed", {31'b0, fin}, 32'h1);
    chk("busy_cycles", nb, exp_nb);
    i_valid = 1'b0;
  endtask

  initial begin
    int unsigned r;
    resp_t       rs;
    rst = 1'b1; mar = '0; mdr = '0; mem_width = '0; mem_load = 1'b0; mem_store = 1'b0;
    wr_val = '0; wr_result = 1'b0; rd_sel = '0; i_valid = 1'b0;
    d_ack = 1'b0; d_error = 1'b0; d_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {d_access, d_wr_en, busy, wb_en, i_valid_out, data_abort, d_bytesel, wb_rd_sel},
        32'h0);
    chk("rst_buses", d_addr | d_wr_val | wb_val, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue_mem(32'h1000, 32'h0, 2'b10, 1'b0, 1'b1, 4'd3, R_ACK, 3, 32'hDEADBEEF);
    issue_mem(32'h1003, 32'hA5, 2'b00, 1'b1, 1'b1, 4'd5, R_ACK, 2, 32'h0);
    issue_mem(32'h2002, 32'h0, 2'b01, 1'b0, 1'b1, 4'd7, R_ACK, 1, 32'h12345678);
    issue_mem(32'h1001, 32'h0, 2'b10, 1'b0, 1'b1, 4'd2, R_ACK, 1, 32'h0);
    issue_mem(32'h3000, 32'h55AA_1234, 2'b10, 1'b1, 1'b0, 4'd0, R_ERR, 2, 32'h0);
    issue_mem(32'h4000, 32'h0, 2'b10, 1'b0, 1'b1, 4'd1, R_TMO, 0, 32'h0);
    issue_mem(32'h4004, 32'h0, 2'b10, 1'b0, 1'b1, 4'd1, R_BOTH, 1, 32'h0);
    issue_mem(32'h4008, 32'h0, 2'b11, 1'b0, 1'b1, 4'd1, R_ACK, 1, 32'h0);
    issue_mem(32'h400C, 32'h0, 2'b10, 1'b0, 1'b1, 4'd9, R_ACK, TO, 32'hCAFEF00D);
    issue_alu(32'h0BAD_F00D, 1'b1, 4'd4);
    issue_alu(32'h1234_5678, 1'b0, 4'd6);

    mar = 32'h5000; mem_width = 2'b10; mem_load = 1'b1; mem_store = 1'b0;
    wr_result = 1'b1; rd_sel = 4'd8; i_valid = 1'b1;
    bus_q.push_back('{addr: 32'h5000, wr_val: mdr, bytesel: 4'hF, wr_en: 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {d_access, d_wr_en, busy, wb_en, i_valid_out, data_abort, d_bytesel, wb_rd_sel},
        32'h0);
    chk("midrst_buses", d_addr | d_wr_val | wb_val, 32'h0);
    d_ack = 1'b1; d_data = $urandom;
    @(posedge clk); #1;
    d_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", {29'b0, d_access, i_valid_out, wb_en}, 32'h0);
    @(posedge clk); #1;
    issue_mem(32'h6001, 32'h0, 2'b00, 1'b0, 1'b1, 4'd10, R_ACK, 2, 32'h00C3_0000);

    for (int unsigned n = 0; n < 300; n++) begin
      idle($urandom_range(2, 0));
      if ($urandom_range(99) < 40) begin
        issue_alu($urandom, 1'($urandom), 4'($urandom));
      end else begin
        r = $urandom_range(99);
        rs = (r < 65) ? R_ACK : (r < 78) ? R_ERR : (r < 88) ? R_BOTH : R_TMO;
        issue_mem($urandom & 32'hFFFF_FFF3 | (32'($urandom_range(3, 0)) & 32'h3) |
                  ($urandom_range(1) != 0 ? 32'h0 : 32'h0),
                  $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                  rs, $urandom_range(TO, 1), $urandom);
      end
    end

    idle(5);
    chk("wb_queue_drained", exp_q.size(), 32'h0);
    chk("bus_queue_drained", bus_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
